// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART constants and FSM state encodings
package uart_tx_fifo_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  localparam int UART_DATA_BITS   = 8;
  // 100 MHz / 115200 baud; shared with the receive side
  localparam int UART_DEFAULT_DIV = 868;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - write/clear controls and line/status outputs of the UART transmitter
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  logic                      clr;
  logic                      tx_write;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      txd;
  logic                      tx_busy;
  logic                      tx_empty;
  logic                      tx_full;
  logic [LW-1:0]             tx_level;
  logic                      tx_overflow;

  modport master (
    output clr, tx_write, tx_data,
    input  txd, tx_busy, tx_empty, tx_full, tx_level, tx_overflow
  );

  modport slave (
    input  clr, tx_write, tx_data,
    output txd, tx_busy, tx_empty, tx_full, tx_level, tx_overflow
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count, so a write at full is dropped even if a pop happens that edge
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  assign empty = (count == '0);
  assign full  = (count == LEVEL_FULL);
  assign level = count;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter producing 8N1/8N2 frames on txd
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_DIV   = UART_DEFAULT_DIV,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_fifo_if.slave    bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  uart_state_t               state;
  logic [CW-1:0]             baud_cnt;
  logic [2:0]                bit_idx;
  logic                      stop_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      txd_q;
  logic                      overflow_q;

  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic [LW-1:0]             fifo_level;
  logic                      fifo_pop;
  logic                      baud_last;
  logic                      frame_end;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == ST_STOP) && baud_last && (stop_idx == STOP_LAST);
  // Pop on the same edge the FSM loads the shift register: from IDLE, or at the last stop-bit boundary
  assign fifo_pop  = !bus.clr && !fifo_empty && ((state == ST_IDLE) || frame_end);

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .push  (bus.tx_write),
    .pop   (fifo_pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else if (bus.clr) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (bus.tx_write && fifo_full) overflow_q <= 1'b1;

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift <= fifo_dout;
            state <= ST_START;
            txd_q <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= ST_DATA;
            txd_q    <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              stop_idx <= 1'b0;
              state    <= ST_STOP;
              txd_q    <= 1'b1;
            end else begin
              // txd is loaded with the bit that will sit in shift[0] after this shift
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
              txd_q   <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              if (!fifo_empty) begin
                shift <= fifo_dout;
                state <= ST_START;
                txd_q <= 1'b0;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd         = txd_q;
  assign bus.tx_busy     = (state != ST_IDLE);
  assign bus.tx_empty    = fifo_empty;
  assign bus.tx_full     = fifo_full;
  assign bus.tx_level    = fifo_level;
  assign bus.tx_overflow = overflow_q;

endmodule
